riscv_dmem_tcm: RTL and testbench

Tightly-coupled data memory that acts as the responder on the core's dmem request/acknowledge interface, the side the LSU drives. It accepts one request at a time and performs byte, halfword or word reads and writes with byte-lane enables. It checks alignment and address range, and provides an LR/SC-style reservation through `dmem_lock_i`. It sits between the core's EX/LSU data port and on-chip SRAM, replacing the BIU/dcache path in small configurations.

---
 rtl/biu_constants_pkg.sv | 11 +
 rtl/riscv_dmem_pkg.sv | 30 +++
 rtl/riscv_dmem_tcm_if.sv | 25 ++
 rtl/riscv_dmem_ram.sv | 29 ++
 rtl/riscv_dmem_tcm.sv | 157 +++++++++++++++
 tb/tb_riscv_dmem_tcm.sv | 263 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/biu_constants_pkg.sv
// Bus interface constants shared by the core's memory ports.
package biu_constants_pkg;

  typedef enum logic [2:0] {
    BYTE  = 3'b000,
    HWORD = 3'b001,
    WORD  = 3'b010,
    DWORD = 3'b011
  } biu_size_t;

endpackage

// File: rtl/riscv_dmem_pkg.sv
// Types and helpers for the tightly-coupled data memory.
package riscv_dmem_pkg;
  import biu_constants_pkg::*;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dmem_state_t;

  function automatic logic [3:0] size2be(biu_size_t size, logic [1:0] adr);
    case (size)
      BYTE:    size2be = 4'b0001 << adr;
      HWORD:   size2be = 4'b0011 << adr;
      WORD:    size2be = 4'b1111;
      default: size2be = 4'b0000;
    endcase
  endfunction

  // DWORD cannot be served by a 32-bit memory, so it is always flagged.
  function automatic logic is_misaligned(biu_size_t size, logic [1:0] adr);
    case (size)
      BYTE:    is_misaligned = 1'b0;
      HWORD:   is_misaligned = adr[0];
      WORD:    is_misaligned = |adr;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/riscv_dmem_tcm_if.sv
// dmem request/acknowledge bus between the LSU (master) and the data TCM (slave).
interface riscv_dmem_tcm_if #(
  parameter int MXLEN = 32
);
  logic                          dmem_req_i;
  logic                          dmem_lock_i;
  logic [MXLEN-1:0]              dmem_adr_i;
  biu_constants_pkg::biu_size_t  dmem_size_i;
  logic                          dmem_we_i;
  logic [MXLEN-1:0]              dmem_d_i;
  logic [MXLEN-1:0]              dmem_q_o;
  logic                          dmem_ack_o;
  logic                          dmem_misaligned_o;
  logic                          dmem_page_fault_o;

  modport master (
    output dmem_req_i, dmem_lock_i, dmem_adr_i, dmem_size_i, dmem_we_i, dmem_d_i,
    input  dmem_q_o, dmem_ack_o, dmem_misaligned_o, dmem_page_fault_o
  );

  modport slave (
    input  dmem_req_i, dmem_lock_i, dmem_adr_i, dmem_size_i, dmem_we_i, dmem_d_i,
    output dmem_q_o, dmem_ack_o, dmem_misaligned_o, dmem_page_fault_o
  );
endinterface

// File: rtl/riscv_dmem_ram.sv
// Single-port synchronous RAM with per-byte write enables and registered read.
module riscv_dmem_ram #(
  parameter  int MXLEN = 32,
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [MXLEN/8-1:0] be_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [MXLEN-1:0]   d_i,
  output logic [MXLEN-1:0]   q_o
);

  logic [MXLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < MXLEN/8; i++) begin
          if (be_i[i]) mem[addr_i][i*8 +: 8] <= d_i[i*8 +: 8];
        end
      end
      q_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/riscv_dmem_tcm.sv
// Tightly-coupled data memory responding to the core's dmem port, with
// alignment/range checks and a single LR/SC reservation.
module riscv_dmem_tcm
  import biu_constants_pkg::*;
  import riscv_dmem_pkg::*;
#(
  parameter int               MXLEN   = 32,
  parameter int               DEPTH   = 1024,
  parameter logic [MXLEN-1:0] BASE    = '0,
  parameter int               LATENCY = 1
) (
  input logic              rst_ni,
  input logic              clk_i,
  riscv_dmem_tcm_if.slave  dmem
);

  localparam int               AW        = $clog2(DEPTH);
  localparam logic [MXLEN-1:0] SPAN      = MXLEN'(DEPTH*4);
  localparam logic [1:0]       CNT_START = 2'(LATENCY-1);

  dmem_state_t      state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             go;

  logic [MXLEN-1:0] adr_p0, d_p0;
  biu_size_t        size_p0;
  logic             we_p0, lock_p0;

  logic [MXLEN-1:0] cur_adr, cur_d, offset;
  biu_size_t        cur_size;
  logic             cur_we, cur_lock;
  logic [AW-1:0]    idx;
  logic             mis, pf, err, resv_hit, wr_ok, rd_en;

  logic             resv_vld_q;
  logic [AW-1:0]    resv_idx_q;
  logic             rd_ok_q, sc_fail_q, mis_q, pf_q;
  logic [MXLEN-1:0] ram_q;
  logic             ram_en;

  // The edge that enters ACK from IDLE sees the request on the bus; from WAIT
  // it uses the copy latched at acceptance.
  always_comb begin
    if (state_q == IDLE) begin
      cur_adr  = dmem.dmem_adr_i;
      cur_d    = dmem.dmem_d_i;
      cur_size = dmem.dmem_size_i;
      cur_we   = dmem.dmem_we_i;
      cur_lock = dmem.dmem_lock_i;
    end else begin
      cur_adr  = adr_p0;
      cur_d    = d_p0;
      cur_size = size_p0;
      cur_we   = we_p0;
      cur_lock = lock_p0;
    end
  end

  assign offset   = cur_adr - BASE;
  assign idx      = offset[AW+1:2];
  assign pf       = (offset >= SPAN);
  assign mis      = is_misaligned(cur_size, cur_adr[1:0]);
  assign err      = mis | pf;
  assign resv_hit = resv_vld_q && (resv_idx_q == idx);
  assign wr_ok    = cur_we && !err && (!cur_lock || resv_hit);
  assign rd_en    = !cur_we && !err;
  // Gating with rst_ni keeps a reset on the commit edge from writing the array.
  assign ram_en   = go && rst_ni && (wr_ok || rd_en);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go      = 1'b0;
    case (state_q)
      IDLE: begin
        if (dmem.dmem_req_i) begin
          cnt_d = CNT_START;
          if (CNT_START == 2'd0) begin
            state_d = ACK;
            go      = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = ACK;
          go      = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      resv_vld_q <= 1'b0;
      rd_ok_q    <= 1'b0;
      sc_fail_q  <= 1'b0;
      mis_q      <= 1'b0;
      pf_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (go) begin
        mis_q     <= mis;
        pf_q      <= pf;
        rd_ok_q   <= rd_en;
        sc_fail_q <= cur_we && cur_lock && !err && !resv_hit;
        if (!err) begin
          if (!cur_we && cur_lock)                resv_vld_q <= 1'b1;
          else if (cur_we && (cur_lock || resv_hit)) resv_vld_q <= 1'b0;
        end
      end
    end
  end

  // Request capture at acceptance
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && dmem.dmem_req_i) begin
      adr_p0  <= dmem.dmem_adr_i;
      d_p0    <= dmem.dmem_d_i;
      size_p0 <= dmem.dmem_size_i;
      we_p0   <= dmem.dmem_we_i;
      lock_p0 <= dmem.dmem_lock_i;
    end
    if (go && !err && !cur_we && cur_lock) resv_idx_q <= idx;
  end

  riscv_dmem_ram #(
    .MXLEN (MXLEN),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i  (clk_i),
    .en_i   (ram_en),
    .we_i   (wr_ok),
    .be_i   (size2be(cur_size, cur_adr[1:0])),
    .addr_i (idx),
    .d_i    (cur_d),
    .q_o    (ram_q)
  );

  // ram_q only moves on commit edges, so the output mux holds between acks.
  assign dmem.dmem_q_o          = rd_ok_q ? ram_q : {{(MXLEN-1){1'b0}}, sc_fail_q};
  assign dmem.dmem_ack_o        = (state_q == ACK);
  assign dmem.dmem_misaligned_o = mis_q;
  assign dmem.dmem_page_fault_o = pf_q;

  req_held_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == WAIT) |-> dmem.dmem_req_i);

endmodule

// File: tb/tb_riscv_dmem_tcm.sv
// Directed bench for riscv_dmem_tcm: three instances cover LATENCY 1, 3 and 4.
module tb_riscv_dmem_tcm;
  import biu_constants_pkg::*;
  import riscv_dmem_pkg::*;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic rst_ni, rst3_n;
  int   checks = 0;
  int   errors = 0;

  riscv_dmem_tcm_if #(.MXLEN(32)) bus1 ();
  riscv_dmem_tcm_if #(.MXLEN(32)) bus3 ();
  riscv_dmem_tcm_if #(.MXLEN(32)) bus4 ();

  riscv_dmem_tcm #(.MXLEN(32), .DEPTH(1024), .BASE(32'h0), .LATENCY(1)) u_dut1 (
    .rst_ni (rst_ni), .clk_i (clk_i), .dmem (bus1.slave));
  riscv_dmem_tcm #(.MXLEN(32), .DEPTH(1024), .BASE(32'h0), .LATENCY(3)) u_dut3 (
    .rst_ni (rst3_n), .clk_i (clk_i), .dmem (bus3.slave));
  riscv_dmem_tcm #(.MXLEN(32), .DEPTH(1024), .BASE(32'h8000_0000), .LATENCY(4)) u_dut4 (
    .rst_ni (rst_ni), .clk_i (clk_i), .dmem (bus4.slave));

  task automatic drive(input int sel, input logic req, input logic lock, input logic we,
                       input biu_size_t size, input logic [31:0] adr, input logic [31:0] d);
    case (sel)
      1: begin
        bus1.dmem_req_i = req; bus1.dmem_lock_i = lock; bus1.dmem_we_i = we;
        bus1.dmem_size_i = size; bus1.dmem_adr_i = adr; bus1.dmem_d_i = d;
      end
      3: begin
        bus3.dmem_req_i = req; bus3.dmem_lock_i = lock; bus3.dmem_we_i = we;
        bus3.dmem_size_i = size; bus3.dmem_adr_i = adr; bus3.dmem_d_i = d;
      end
      default: begin
        bus4.dmem_req_i = req; bus4.dmem_lock_i = lock; bus4.dmem_we_i = we;
        bus4.dmem_size_i = size; bus4.dmem_adr_i = adr; bus4.dmem_d_i = d;
      end
    endcase
  endtask

  task automatic sample(input int sel, output logic ack, output logic [31:0] q,
                        output logic mis, output logic pf);
    case (sel)
      1: begin
        ack = bus1.dmem_ack_o; q = bus1.dmem_q_o;
        mis = bus1.dmem_misaligned_o; pf = bus1.dmem_page_fault_o;
      end
      3: begin
        ack = bus3.dmem_ack_o; q = bus3.dmem_q_o;
        mis = bus3.dmem_misaligned_o; pf = bus3.dmem_page_fault_o;
      end
      default: begin
        ack = bus4.dmem_ack_o; q = bus4.dmem_q_o;
        mis = bus4.dmem_misaligned_o; pf = bus4.dmem_page_fault_o;
      end
    endcase
  endtask

  // One transfer; lat counts edges from the accept edge through the ack cycle.
  task automatic xfer(input int sel, input logic lock, input logic we, input biu_size_t size,
                      input logic [31:0] adr, input logic [31:0] d,
                      output logic [31:0] q, output logic mis, output logic pf, output int lat);
    logic a;
    a = 1'b0;
    lat = 0;
    @(negedge clk_i);
    drive(sel, 1'b1, lock, we, size, adr, d);
    while (!a && lat < 20) begin
      @(posedge clk_i); #1;
      lat++;
      sample(sel, a, q, mis, pf);
    end
    drive(sel, 1'b0, 1'b0, 1'b0, BYTE, 32'h0, 32'h0);
    if (!a) begin
      checks++; errors++;
      $display("FAIL xfer_timeout dut%0d adr=%h: no ack within 20 cycles", sel, adr);
      lat = -1;
    end
    @(posedge clk_i);
  endtask

  task automatic test_reset();
    logic a; logic [31:0] q; logic m, p;
    sample(1, a, q, m, p);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", a); end
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL reset_q got=%h exp=0", q); end
    checks++; if (m !== 1'b0) begin errors++; $display("FAIL reset_mis got=%b exp=0", m); end
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL reset_pf got=%b exp=0", p); end
    sample(4, a, q, m, p);
    checks++; if ({a, q, m, p} !== 35'h0) begin errors++; $display("FAIL reset_dut4 got=%h exp=0", {a, q, m, p}); end
    checks++; if (u_dut3.state_q !== IDLE) begin errors++; $display("FAIL reset_state3 got=%0d exp=%0d", u_dut3.state_q, IDLE); end
  endtask

  task automatic test_word_rw();
    logic [31:0] q; logic m, p; int lat;
    xfer(1, 1'b0, 1'b1, WORD, 32'h10, 32'hDEAD_BEEF, q, m, p, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL word_wr_lat got=%0d exp=1", lat); end
    checks++; if ({m, p} !== 2'b00) begin errors++; $display("FAIL word_wr_err got=%b exp=00", {m, p}); end
    xfer(1, 1'b0, 1'b0, WORD, 32'h10, 32'h0, q, m, p, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL word_rd_lat got=%0d exp=1", lat); end
    checks++; if (q !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_rd_q got=%h exp=deadbeef", q); end
  endtask

  task automatic test_byte_merge();
    logic [31:0] q; logic m, p; int lat;
    xfer(1, 1'b0, 1'b1, BYTE, 32'h12, 32'h00AA_0000, q, m, p, lat);
    xfer(1, 1'b0, 1'b0, WORD, 32'h10, 32'h0, q, m, p, lat);
    checks++; if (q !== 32'hDEAA_BEEF) begin errors++; $display("FAIL byte_merge got=%h exp=deaabeef", q); end
    xfer(1, 1'b0, 1'b1, WORD, 32'h14, 32'h1122_3344, q, m, p, lat);
    xfer(1, 1'b0, 1'b1, HWORD, 32'h16, 32'hCAFE_0000, q, m, p, lat);
    xfer(1, 1'b0, 1'b0, WORD, 32'h14, 32'h0, q, m, p, lat);
    checks++; if (q !== 32'hCAFE_3344) begin errors++; $display("FAIL hword_merge got=%h exp=cafe3344", q); end
  endtask

  task automatic test_errors();
    logic [31:0] q; logic m, p; int lat;
    xfer(1, 1'b0, 1'b1, WORD, 32'h0, 32'h0000_5A5A, q, m, p, lat);
    xfer(1, 1'b0, 1'b0, WORD, 32'h10, 32'h0, q, m, p, lat);
    xfer(1, 1'b0, 1'b1, HWORD, 32'h11, 32'hFFFF_FFFF, q, m, p, lat);
    checks++; if ({m, p} !== 2'b10) begin errors++; $display("FAIL hword_mis got=%b exp=10", {m, p}); end
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL hword_mis_q got=%h exp=0", q); end
    xfer(1, 1'b0, 1'b0, WORD, 32'h10, 32'h0, q, m, p, lat);
    checks++; if (q !== 32'hDEAA_BEEF) begin errors++; $display("FAIL mis_unchanged got=%h exp=deaabeef", q); end
    xfer(1, 1'b0, 1'b1, WORD, 32'h1000, 32'hFFFF_FFFF, q, m, p, lat);
    checks++; if ({m, p} !== 2'b01) begin errors++; $display("FAIL page_fault got=%b exp=01", {m, p}); end
    xfer(1, 1'b0, 1'b0, WORD, 32'h0, 32'h0, q, m, p, lat);
    checks++; if (q !== 32'h0000_5A5A) begin errors++; $display("FAIL pf_unchanged got=%h exp=00005a5a", q); end
    xfer(1, 1'b0, 1'b0, DWORD, 32'h18, 32'h0, q, m, p, lat);
    checks++; if ({m, p, q} !== {2'b10, 32'h0}) begin errors++; $display("FAIL dword_mis got=%b/%h exp=10/0", {m, p}, q); end
    xfer(1, 1'b0, 1'b0, WORD, 32'h1002, 32'h0, q, m, p, lat);
    checks++; if ({m, p} !== 2'b11) begin errors++; $display("FAIL both_err got=%b exp=11", {m, p}); end
  endtask

  task automatic test_lrsc();
    logic [31:0] q; logic m, p; int lat;
    xfer(1, 1'b0, 1'b1, WORD, 32'h20, 32'h77, q, m, p, lat);
    xfer(1, 1'b0, 1'b1, WORD, 32'h24, 32'h44, q, m, p, lat);
    xfer(1, 1'b1, 1'b0, WORD, 32'h20, 32'h0, q, m, p, lat);
    checks++; if (q !== 32'h77) begin errors++; $display("FAIL lr_q got=%h exp=77", q); end
    xfer(1, 1'b1, 1'b1, WORD, 32'h20, 32'h5, q, m, p, lat);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL sc_ok got=%h exp=0", q); end
    xfer(1, 1'b0, 1'b0, WORD, 32'h20, 32'h0, q, m, p, lat);
    checks++; if (q !== 32'h5) begin errors++; $display("FAIL sc_ok_data got=%h exp=5", q); end
    xfer(1, 1'b1, 1'b1, WORD, 32'h20, 32'h9, q, m, p, lat);
    checks++; if (q !== 32'h1) begin errors++; $display("FAIL sc_again got=%h exp=1", q); end
    xfer(1, 1'b0, 1'b0, WORD, 32'h20, 32'h0, q, m, p, lat);
    checks++; if (q !== 32'h5) begin errors++; $display("FAIL sc_again_data got=%h exp=5", q); end
    xfer(1, 1'b1, 1'b0, WORD, 32'h20, 32'h0, q, m, p, lat);
    xfer(1, 1'b0, 1'b1, WORD, 32'h20, 32'h6, q, m, p, lat);
    xfer(1, 1'b1, 1'b1, WORD, 32'h20, 32'h7, q, m, p, lat);
    checks++; if (q !== 32'h1) begin errors++; $display("FAIL sc_after_st got=%h exp=1", q); end
    xfer(1, 1'b0, 1'b0, WORD, 32'h20, 32'h0, q, m, p, lat);
    checks++; if (q !== 32'h6) begin errors++; $display("FAIL sc_after_st_data got=%h exp=6", q); end
    xfer(1, 1'b1, 1'b0, WORD, 32'h20, 32'h0, q, m, p, lat);
    xfer(1, 1'b1, 1'b1, WORD, 32'h24, 32'hEE, q, m, p, lat);
    checks++; if (q !== 32'h1) begin errors++; $display("FAIL sc_other_idx got=%h exp=1", q); end
    xfer(1, 1'b0, 1'b0, WORD, 32'h24, 32'h0, q, m, p, lat);
    checks++; if (q !== 32'h44) begin errors++; $display("FAIL sc_other_data got=%h exp=44", q); end
    xfer(1, 1'b1, 1'b1, WORD, 32'h20, 32'h8, q, m, p, lat);
    checks++; if (q !== 32'h1) begin errors++; $display("FAIL sc_cleared got=%h exp=1", q); end
  endtask

  task automatic test_back_to_back();
    logic a; logic [31:0] q, q2; logic m, p, m2, p2, ack_after;
    int t, nack, first, second;
    t = 0; nack = 0; first = -1; second = -1; q2 = '0; m2 = 1'b1; p2 = 1'b1; ack_after = 1'bx;
    @(negedge clk_i);
    drive(4, 1'b1, 1'b0, 1'b1, WORD, 32'h8000_0040, 32'hA5A5_A5A5);
    while (t < 30 && nack < 2) begin
      @(posedge clk_i); #1;
      t++;
      sample(4, a, q, m, p);
      if (t == first + 1) ack_after = a;
      if (a) begin
        nack++;
        if (nack == 1) begin
          first = t;
          drive(4, 1'b1, 1'b0, 1'b0, WORD, 32'h8000_0040, 32'h0);
        end else begin
          second = t; q2 = q; m2 = m; p2 = p;
        end
      end
    end
    drive(4, 1'b0, 1'b0, 1'b0, BYTE, 32'h0, 32'h0);
    checks++; if (first !== 4) begin errors++; $display("FAIL b2b_first_lat got=%0d exp=4", first); end
    checks++; if (second - first !== 5) begin errors++; $display("FAIL b2b_spacing got=%0d exp=5", second - first); end
    checks++; if (ack_after !== 1'b0) begin errors++; $display("FAIL b2b_double_ack got=%b exp=0", ack_after); end
    checks++; if ({m2, p2, q2} !== {2'b00, 32'hA5A5_A5A5}) begin errors++; $display("FAIL b2b_read got=%b/%h exp=00/a5a5a5a5", {m2, p2}, q2); end
    nack = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
      sample(4, a, q, m, p);
      if (a) nack++;
    end
    checks++; if (nack !== 0) begin errors++; $display("FAIL b2b_extra_ack got=%0d exp=0", nack); end
    xfer(4, 1'b0, 1'b0, WORD, 32'h0000_0040, 32'h0, q, m, p, t);
    checks++; if ({m, p, q} !== {2'b01, 32'h0}) begin errors++; $display("FAIL below_base got=%b/%h exp=01/0", {m, p}, q); end
  endtask

  task automatic test_reset_mid();
    logic a; logic [31:0] q; logic m, p; int lat, nack;
    xfer(3, 1'b0, 1'b1, WORD, 32'h30, 32'h0BAD_F00D, q, m, p, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL lat3 got=%0d exp=3", lat); end
    xfer(3, 1'b1, 1'b0, WORD, 32'h30, 32'h0, q, m, p, lat);
    checks++; if (q !== 32'h0BAD_F00D) begin errors++; $display("FAIL lr3_q got=%h exp=0badf00d", q); end
    @(negedge clk_i);
    drive(3, 1'b1, 1'b0, 1'b1, WORD, 32'h30, 32'h1234);
    @(posedge clk_i); #1;
    checks++; if (u_dut3.state_q !== WAIT) begin errors++; $display("FAIL mid_in_wait got=%0d exp=%0d", u_dut3.state_q, WAIT); end
    @(negedge clk_i);
    rst3_n = 1'b0;
    #1;
    sample(3, a, q, m, p);
    checks++; if ({a, q, m, p} !== 35'h0) begin errors++; $display("FAIL mid_outputs got=%h exp=0", {a, q, m, p}); end
    checks++; if (u_dut3.state_q !== IDLE) begin errors++; $display("FAIL mid_state got=%0d exp=%0d", u_dut3.state_q, IDLE); end
    checks++; if (u_dut3.resv_vld_q !== 1'b0) begin errors++; $display("FAIL mid_resv got=%b exp=0", u_dut3.resv_vld_q); end
    @(negedge clk_i);
    drive(3, 1'b0, 1'b0, 1'b0, BYTE, 32'h0, 32'h0);
    rst3_n = 1'b1;
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i); #1;
      sample(3, a, q, m, p);
      if (a) nack++;
    end
    checks++; if (nack !== 0) begin errors++; $display("FAIL mid_no_ack got=%0d exp=0", nack); end
    xfer(3, 1'b0, 1'b0, WORD, 32'h30, 32'h0, q, m, p, lat);
    checks++; if (q !== 32'h0BAD_F00D) begin errors++; $display("FAIL mid_no_write got=%h exp=0badf00d", q); end
    xfer(3, 1'b1, 1'b1, WORD, 32'h30, 32'h55, q, m, p, lat);
    checks++; if (q !== 32'h1) begin errors++; $display("FAIL mid_sc_fail got=%h exp=1", q); end
  endtask

  initial begin
    rst_ni = 1'b0;
    rst3_n = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, BYTE, 32'h0, 32'h0);
    drive(3, 1'b0, 1'b0, 1'b0, BYTE, 32'h0, 32'h0);
    drive(4, 1'b0, 1'b0, 1'b0, BYTE, 32'h0, 32'h0);
    repeat (3) @(posedge clk_i);
    #1;
    test_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    rst3_n = 1'b1;
    @(posedge clk_i);
    test_word_rw();
    test_byte_merge();
    test_errors();
    test_lrsc();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
